// File: rtl/iomem_pkg.sv
// ---------------------------------------------------------------------------
// iomem_pkg
// Shared definitions for the iomem initiator and the top-level peripheral
// decoder.
//   iomem_state_t       : initiator FSM states (IDLE, BUS, RESP)
//   IOMEM_WORD_BYTES    : address step between consecutive burst words
//   IOMEM_SEL_*         : peripheral base selectors (address bits [31:24])
// ---------------------------------------------------------------------------
package iomem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } iomem_state_t;

    localparam int unsigned IOMEM_WORD_BYTES = 4;

    localparam logic [7:0] IOMEM_SEL_GPIO      = 8'h03;
    localparam logic [7:0] IOMEM_SEL_AUDIO     = 8'h04;
    localparam logic [7:0] IOMEM_SEL_VIDEO     = 8'h05;
    localparam logic [7:0] IOMEM_SEL_SD        = 8'h06;
    localparam logic [7:0] IOMEM_SEL_I2C       = 8'h07;
    localparam logic [7:0] IOMEM_SEL_FLASH     = 8'h08;
    localparam logic [7:0] IOMEM_SEL_WARM_BOOT = 8'h09;

endpackage

// File: rtl/iomem_initiator_if.sv
// ---------------------------------------------------------------------------
// iomem_initiator_if
// Bundles the three handshakes around the initiator:
//   req_*   : command port (agent -> initiator), valid/ready
//   rsp_*   : per-word response port (initiator -> agent), valid/ready
//   iomem_* : PicoSoC iomem bus (initiator -> peripheral mux), valid/ready
// Modports:
//   master : the initiator itself (bus master on iomem)
//   slave  : the surroundings (command source, response sink, peripherals)
// ---------------------------------------------------------------------------
interface iomem_initiator_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [7:0]  req_len;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_last;

    logic        iomem_valid;
    logic        iomem_ready;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, req_len,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_last,
        input  rsp_ready,
        output iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, req_len,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_last,
        output rsp_ready,
        input  iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb,
        output iomem_ready, iomem_rdata
    );

endinterface

// File: rtl/iomem_watchdog.sv
// ---------------------------------------------------------------------------
// iomem_watchdog
// Counts bus cycles a word has waited for iomem_ready and flags the cycle in
// which the wait budget runs out. Only instantiated when the initiator is
// built with IOMEM_INITIATOR_TIMEOUT_EN.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   active      : initiator is in BUS (counter is cleared otherwise)
//   ready       : iomem_ready from the peripheral mux
//   expired     : this BUS cycle is the last allowed one and ready is low
// Parameter:
//   TIMEOUT_CYCLES : BUS cycles allowed per word (2..65535)
// ---------------------------------------------------------------------------
module iomem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic active,
    input  logic ready,
    output logic expired
);

    // wait_count holds the number of BUS cycles already spent without ready,
    // so the Nth BUS cycle sees N-1 and is the terminal one.
    localparam logic [15:0] TERMINAL = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_count <= 16'd0;
        end else if (!active) begin
            wait_count <= 16'd0;
        end else if (!ready) begin
            wait_count <= wait_count + 16'd1;
        end
    end

    // Ready in the terminal cycle completes the word normally.
    assign expired = active && !ready && (wait_count == TERMINAL);

endmodule

// File: rtl/iomem_initiator.sv
// ---------------------------------------------------------------------------
// iomem_initiator
// Bus-master engine for the PicoSoC iomem fabric. Accepts single or burst
// word commands, runs one iomem handshake per word and returns one response
// per word (read data, error, last-word flag).
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : iomem_initiator_if.master (req_*, rsp_*, iomem_*)
// Configuration:
//   IOMEM_INITIATOR_TIMEOUT_EN : when defined, a word waiting TIMEOUT_CYCLES
//   bus cycles for iomem_ready is aborted with rsp_err=1 and ends the burst.
//   When undefined, BUS waits forever and rsp_err is tied 0.
// ---------------------------------------------------------------------------
module iomem_initiator
    import iomem_pkg::*;
`ifdef IOMEM_INITIATOR_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
    input  logic               clk,
    input  logic               resetn,
    iomem_initiator_if.master  bus
);

    iomem_state_t state;
    iomem_state_t state_next;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [7:0]  remaining_q;
    logic        is_write_q;

    logic        iomem_valid_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_last_q;

    logic        timeout;
    logic        word_done;

`ifdef IOMEM_INITIATOR_TIMEOUT_EN
    logic        rsp_err_q;

    iomem_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .active  (state == ST_BUS),
        .ready   (bus.iomem_ready),
        .expired (timeout)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_err_q <= 1'b0;
        end else if (state == ST_BUS && word_done) begin
            rsp_err_q <= timeout;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // A word leaves BUS on ready or, with the watchdog, on expiry; expiry
    // already excludes ready, so ready always wins a tie.
    assign word_done = bus.iomem_ready || timeout;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (bus.req_valid) state_next = ST_BUS;
            ST_BUS:  if (word_done)     state_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_next = rsp_last_q ? ST_IDLE : ST_BUS;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // Valid flags are registered copies of the next state so every output
    // except req_ready comes straight from a flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_valid_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            wstrb_q       <= 4'd0;
            remaining_q   <= 8'd0;
            is_write_q    <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_last_q    <= 1'b0;
        end else begin
            iomem_valid_q <= (state_next == ST_BUS);
            rsp_valid_q   <= (state_next == ST_RESP);
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= {bus.req_addr[31:2], 2'b00};
                        remaining_q <= bus.req_len;
                        is_write_q  <= bus.req_write;
                        wdata_q     <= bus.req_wdata;
                        // A zero strobe is what marks a read on iomem.
                        wstrb_q     <= bus.req_write ? bus.req_wstrb : 4'b0000;
                    end
                end
                ST_BUS: begin
                    if (word_done) begin
                        rsp_rdata_q <= (bus.iomem_ready && !is_write_q) ? bus.iomem_rdata : 32'd0;
                        rsp_last_q  <= (remaining_q == 8'd0) || timeout;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready && !rsp_last_q) begin
                        addr_q      <= addr_q + 32'(IOMEM_WORD_BYTES);
                        remaining_q <= remaining_q - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.iomem_valid = iomem_valid_q;
    assign bus.iomem_addr  = addr_q;
    assign bus.iomem_wdata = wdata_q;
    assign bus.iomem_wstrb = wstrb_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_last    = rsp_last_q;

endmodule

// File: doc/iomem_initiator.md
# iomem_initiator

Bus-master engine driving the PicoSoC `iomem` peripheral bus from the initiator side, so hardware agents such as a debug bridge or DMA front-end can issue reads and writes to the same peripherals the CPU reaches. It accepts word-granular single or burst requests on a valid/ready command port and runs the `iomem` valid/ready handshake one word at a time. It returns one response per word, carrying read data, an error flag and a last-word flag. It sits beside the CPU on the `iomem` fabric, behind the arbiter that owns `iomem_valid`.

## Interface
- TIMEOUT_CYCLES, 1024: bus cycles a word may wait for `iomem_ready` before it is aborted; only used with the timeout option; legal range 2..65535.
- clk  in  1  system clock; the block uses one clock.
- resetn  in  1  reset, asynchronous and active-low.
- req_valid  in  1  a command is presented.
- req_ready  out  1  the command is accepted; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  start byte address; bits [1:0] are ignored.
- req_wdata  in  32  write data, reused for every word of a write burst.
- req_wstrb  in  4  byte enables for writes; ignored for reads.
- req_len  in  8  number of words minus 1 (0 = 1 word, 255 = 256 words).
- rsp_valid  out  1  a response is held.
- rsp_ready  in  1  the consumer takes the response.
- rsp_rdata  out  32  read data; 0 for writes and for errored words.
- rsp_err  out  1  the word timed out.
- rsp_last  out  1  the final response of the command.
- iomem_valid  out  1  bus request.
- iomem_ready  in  1  completion from the peripheral mux.
- iomem_addr  out  32  word-aligned address.
- iomem_wdata  out  32  write data.
- iomem_wstrb  out  4  byte enables; 4'b0000 means a read.
- iomem_rdata  in  32  read data, valid while `iomem_ready` is high.

## Operation
- The FSM has three states: IDLE, BUS and RESP.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid`, latch the command and go to BUS.
  - The latched state is `addr = {req_addr[31:2], 2'b00}`, `remaining = req_len`, write/wdata/wstrb.
- **BUS:**
  - `iomem_valid` = 1.
  - addr, wdata and wstrb stay stable until a cycle with `iomem_ready` = 1.
  - In that cycle, capture `iomem_rdata`, or 0 for a write, and go to RESP.
- **RESP:**
  - `rsp_valid` = 1 and `rsp_last` = (`remaining` == 0 or err).
  - On `rsp_ready` with last set, go to IDLE.
  - Otherwise go to BUS with `addr += 4` and `remaining -= 1`.
- **Address arithmetic:** a 32-bit add modulo 2^32. `0xFFFF_FFFC + 4` wraps to `0x0000_0000` silently.
- **Read bus strobe:** reads drive `iomem_wstrb` = 0 even if `req_wstrb` is nonzero.
- **Back-pressure:** `rsp_ready` low holds RESP indefinitely with all `rsp_*` stable, and no new bus cycle starts.
- **Reset mid-transfer:** any state goes to IDLE and drops `iomem_valid` immediately. No response is produced for the interrupted command.

## Timing
- **Reset values:**
  - `req_ready` = 1.
  - `iomem_valid` = 0, `iomem_addr` = 0, `iomem_wdata` = 0, `iomem_wstrb` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `rsp_last` = 0.
- **Cycle sequence:**
  - Acceptance happens at edge N.
  - `iomem_valid` is high from cycle N+1.
  - If `iomem_ready` is already high at N+1, which is the case for unmapped regions, `rsp_valid` is high at N+2.
- **Throughput:** with `rsp_ready` tied high, the minimum is 2 cycles per word.
- **End of a bus cycle:** `iomem_valid` falls in the cycle after `iomem_ready` is sampled high. This is never a combinational function of `iomem_ready`.
- **Registered outputs:** all outputs come from flops, except `req_ready`, which is decoded from the state.

## Configuration
- Macro: `IOMEM_INITIATOR_TIMEOUT_EN`.
- **Defined:**
  - A wait counter clears on entry to BUS and increments each BUS cycle without ready.
  - When the counter reaches TIMEOUT_CYCLES, leave BUS with `rsp_err` = 1, `rsp_rdata` = 0 and `rsp_last` = 1. The rest of the burst is abandoned.
  - `iomem_valid` drops the next cycle.
  - If `iomem_ready` and the timeout coincide, the ready wins and no error is raised.
- **Undefined:** BUS waits forever, `rsp_err` is tied 0, and no counter logic exists.

## Structure
- Shared package `iomem_pkg` holds:
  - the state enum;
  - `IOMEM_WORD_BYTES` = 4;
  - the peripheral base-selector constants (GPIO 8'h03, audio 8'h04, video 8'h05, SD 8'h06, I2C 8'h07, flash 8'h08, warm boot 8'h09), shared with the top-level decoder.
- Sub-module `iomem_watchdog` contains the wait counter and its terminal-count compare. It is instantiated only under the macro.

## Test plan
- **Single read:** `req_addr` = 0x0300_0004, len 0; the responder returns 0xA5A5_1234 with 3 wait cycles. Expect:
  - `iomem_wstrb` = 0 and `iomem_addr` = 0x0300_0004;
  - one response with rdata 0xA5A5_1234, last = 1, err = 0.
- **Burst write:** `req_addr` = 0x0500_0000, len 3, wstrb 4'b0011, with `iomem_ready` stuck high. Expect:
  - addresses 0x0500_0000, _0004, _0008, _000C in order;
  - 4 responses, last only on the 4th;
  - 8 cycles total.
- **Back-pressure plus wrap:** `req_addr` = 0xFFFF_FFFA, len 1; hold `rsp_ready` low for 5 cycles. Expect:
  - bus addresses 0xFFFF_FFF8 then 0xFFFF_FFFC;
  - no second bus cycle until the first response is taken;
  - a len 2 variant wraps its third address to 0x0000_0000.
- **Timeout:** macro defined, TIMEOUT_CYCLES = 8, `iomem_ready` never asserted, len 2. Expect:
  - one response with err = 1, rdata = 0, last = 1 after 8 BUS cycles;
  - IDLE afterwards.
- **Timeout coincident with ready:** `iomem_ready` rises on exactly the 8th wait cycle. Expect err = 0 and valid rdata.
- **Reset mid-burst:** assert `resetn` low asynchronously in BUS during word 2 of 4. Expect:
  - `iomem_valid` = 0 and `rsp_valid` = 0 without waiting for a clock edge;
  - `req_ready` = 1 after release.
